pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Hazard and stall sequencer for the 5-stage core. It drives the enable and flush controls of the PC register, the fetch/decode latch and the decode/execute latch. It detects load-use hazards and taken-branch flushes, and holds the front end for the full multi-cycle mult/div latency. It sits beside the decode stage and takes instruction fields from the F/D and D/X latch outputs plus the branch-resolution signal from execute.

## Interface
- MD_CYCLES, 32, mult/div unit latency in cycles (≥2, ≤63)
- STALL_CNT_W, 16, width of the stall-cycle performance counter
- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-high
- fd_opcode  in  5  opcode field of the instruction held in F/D
- fd_rs, fd_rt  in  5 each  source register fields in F/D
- dx_opcode  in  5  opcode field in D/X
- dx_rd  in  5  destination register field in D/X
- dx_aluOp  in  5  ALU op field in D/X
- branch_taken  in  1  execute stage has resolved a taken branch or jump this cycle
- pc_enable  out  1  PC register write enable
- fd_enable  out  1  F/D latch write enable
- fd_flush  out  1  F/D latch synchronous clear (loads nop)
- dx_enable  out  1  D/X latch write enable
- dx_bubble  out  1  D/X latch loads nop instead of decode output
- md_start  out  1  one-cycle start pulse to the mult/div unit
- md_busy  out  1  high while the mult/div sequence is in flight
- stall_cycles  out  STALL_CNT_W  count of cycles with pc_enable=0, saturating

## Operation
- Opcodes: R-type 5'b00000; lw 5'b01000. mul = R-type with aluOp 5'b00110; div = R-type with aluOp 5'b00111.
- States: RUN, MD_BUSY.
- RUN, priority order:
  1. branch_taken=1: pc_enable=1, fd_flush=1, dx_bubble=1, fd_enable=1, dx_enable=1. No md_start that cycle; stay in RUN.
  2. D/X holds mul/div: md_start=1; all enables 0 (front end and D/X held); counter←MD_CYCLES-1; next state MD_BUSY.
  3. Load-use: dx_opcode=lw, dx_rd≠0, and (dx_rd=fd_rs or dx_rd=fd_rt). Then pc_enable=0, fd_enable=0, dx_bubble=1, dx_enable=1. One cycle only, because the bubble removes the hazard.
  4. Otherwise all enables 1, flush/bubble 0.
- MD_BUSY:
  - pc_enable=fd_enable=dx_enable=0; md_busy=1.
  - branch_taken is ignored.
  - Counter decrements each cycle. When counter=0: next state RUN, dx_bubble=1 and dx_enable=1 on that final cycle, so the mul/div leaves D/X and is not reissued.
- stall_cycles increments on every cycle with pc_enable=0 and saturates at all-ones.
- Register $0 never causes a load-use stall.

## Timing
- Reset (asynchronous):
  - State RUN, counter 0, stall_cycles 0.
  - Outputs: pc_enable=fd_enable=dx_enable=1, fd_flush=dx_bubble=md_start=md_busy=0.
- All control outputs are combinational from state plus inputs, valid in the same cycle. Only the state, counter and stall_cycles are registered.
- mul/div total front-end hold is exactly MD_CYCLES+1 cycles: one issue cycle plus MD_CYCLES in MD_BUSY.
- md_start is high for exactly one cycle per mul/div. md_busy is high for exactly MD_CYCLES cycles.
- Load-use stall is exactly one cycle.
- Simultaneous events:
  - branch_taken with a load-use match: the flush wins; no stall.
  - A mul/div in D/X followed by a dependent load: handled after return to RUN.
- Reset asserted mid-MD_BUSY: the sequence aborts immediately; md_busy drops asynchronously.

## Structure
- Shared package/include: opcode constants (OP_RTYPE, OP_LW), aluOp constants (ALU_MUL, ALU_DIV), state encoding.
- Sub-module md_countdown: loadable down-counter with zero flag, width ⌈log2(MD_CYCLES)⌉. It is instantiated once.
- Hazard compare and priority mux live in the top module.

## Test plan
- Reset mid-run: assert reset during MD_BUSY with counter=10 -> md_busy=0 and all enables 1 immediately; stall_cycles=0.
- Load-use: D/X lw with dx_rd=5, F/D fd_rs=5 -> one cycle of pc_enable=0, fd_enable=0, dx_bubble=1, then all enables 1; stall_cycles +1. Repeat with dx_rd=0 -> no stall.
- mul issue with MD_CYCLES=32: D/X opcode 0, aluOp 00110 -> md_start for 1 cycle; md_busy for 32 cycles; pc_enable low for 33 cycles; final cycle dx_bubble=1; stall_cycles +33.
- Taken branch with simultaneous load-use match (dx lw rd=3, fd_rt=3) -> fd_flush=1, dx_bubble=1, pc_enable=1; no stall cycle counted.
- branch_taken pulsed during MD_BUSY -> ignored; enables remain 0 until the counter expires.
- Saturation with STALL_CNT_W=4: 20 consecutive stall cycles -> stall_cycles holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
//============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared constants for the hazard/stall sequencer: opcode and
//               ALU-op encodings, sequencer state encoding and a mult/div
//               decode helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
//============================================================================
package pipeline_hazard_ctrl_pkg;

   localparam logic [4:0] OP_RTYPE = 5'b00000;
   localparam logic [4:0] OP_LW    = 5'b01000;
   localparam logic [4:0] ALU_MUL  = 5'b00110;
   localparam logic [4:0] ALU_DIV  = 5'b00111;

   typedef enum logic [0:0] {
      ST_RUN     = 1'b0,
      ST_MD_BUSY = 1'b1
   } state_e;

   // True when the D/X instruction must be handed to the mult/div unit.
   function automatic logic is_md_op(input logic [4:0] opcode,
                                     input logic [4:0] alu_op);
      return (opcode == OP_RTYPE) && ((alu_op == ALU_MUL) || (alu_op == ALU_DIV));
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_md_countdown.sv
`default_nettype none
//============================================================================
// Module      : md_countdown
// Description : Loadable down-counter with zero flag, tracking the remaining
//               mult/div latency. Load has priority over decrement; the
//               counter stops at zero.
// Ports       : clock, reset (async, active-high)
//               load/load_val - load a new count
//               dec           - decrement by one (ignored at zero)
//               zero          - count is zero
// Revision    : 1.0 - initial release
//============================================================================
module md_countdown #(
   parameter int W = 5
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
//============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Hazard and stall sequencer for the 5-stage core. Generates
//               PC / F/D / D/X enables, F/D flush and D/X bubble for
//               taken-branch flushes, load-use stalls and the multi-cycle
//               mult/div hold. Counts stalled cycles (saturating).
// Ports       : clock, reset (async, active-high)
//               fd_opcode, fd_rs, fd_rt           - F/D instruction fields
//               dx_opcode, dx_rd, dx_aluOp        - D/X instruction fields
//               branch_taken                      - taken branch from EX
//               pc_enable, fd_enable, fd_flush,
//               dx_enable, dx_bubble              - pipeline latch controls
//               md_start, md_busy                 - mult/div handshake
//               stall_cycles                      - cycles with pc_enable=0
// Revision    : 1.0 - initial release
//============================================================================
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int MD_CYCLES   = 32,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [4:0]             fd_opcode,
   input  logic [4:0]             fd_rs,
   input  logic [4:0]             fd_rt,
   input  logic [4:0]             dx_opcode,
   input  logic [4:0]             dx_rd,
   input  logic [4:0]             dx_aluOp,
   input  logic                   branch_taken,
   output logic                   pc_enable,
   output logic                   fd_enable,
   output logic                   fd_flush,
   output logic                   dx_enable,
   output logic                   dx_bubble,
   output logic                   md_start,
   output logic                   md_busy,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam int             CNT_W   = $clog2(MD_CYCLES);
   localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_CYCLES - 1);

   state_e                 state_q;
   state_e                 state_d;
   logic [STALL_CNT_W-1:0] stall_cycles_q;
   logic [STALL_CNT_W-1:0] stall_cycles_d;
   logic                   md_load;
   logic                   md_dec;
   logic                   md_zero;
   logic                   load_use;

   // F/D opcode does not qualify the hazard: any source field match against
   // a pending load stalls, which is conservative but always safe.
   logic unused_fd_opcode;
   assign unused_fd_opcode = ^fd_opcode;

   assign load_use = (dx_opcode == OP_LW) && (dx_rd != 5'd0) &&
                     ((dx_rd == fd_rs) || (dx_rd == fd_rt));

   md_countdown #(
      .W (CNT_W)
   ) u_md_countdown (
      .clock    (clock),
      .reset    (reset),
      .load     (md_load),
      .load_val (MD_LOAD),
      .dec      (md_dec),
      .zero     (md_zero)
   );

   always_comb begin
      pc_enable = 1'b1;
      fd_enable = 1'b1;
      fd_flush  = 1'b0;
      dx_enable = 1'b1;
      dx_bubble = 1'b0;
      md_start  = 1'b0;
      md_busy   = 1'b0;
      md_load   = 1'b0;
      md_dec    = 1'b0;
      state_d   = state_q;
      // While reset is held the controls show their idle values even if a
      // mul/div still sits in D/X, so an aborted sequence releases at once.
      if (!reset) begin
         unique case (state_q)
            ST_RUN: begin
               if (branch_taken) begin
                  fd_flush  = 1'b1;
                  dx_bubble = 1'b1;
               end else if (is_md_op(dx_opcode, dx_aluOp)) begin
                  pc_enable = 1'b0;
                  fd_enable = 1'b0;
                  dx_enable = 1'b0;
                  md_start  = 1'b1;
                  md_load   = 1'b1;
                  state_d   = ST_MD_BUSY;
               end else if (load_use) begin
                  pc_enable = 1'b0;
                  fd_enable = 1'b0;
                  dx_bubble = 1'b1;
               end
            end
            ST_MD_BUSY: begin
               pc_enable = 1'b0;
               fd_enable = 1'b0;
               dx_enable = 1'b0;
               md_busy   = 1'b1;
               if (md_zero) begin
                  // Retire the mul/div from D/X so it is not reissued.
                  dx_enable = 1'b1;
                  dx_bubble = 1'b1;
                  state_d   = ST_RUN;
               end else begin
                  md_dec = 1'b1;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (!pc_enable && (stall_cycles_q != '1)) begin
         stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= ST_RUN;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
//============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Directed self-checking bench for pipeline_hazard_ctrl.
//               A second instance with a 4-bit stall counter covers
//               saturation.
// Revision    : 1.0 - initial release
//============================================================================
module tb_pipeline_hazard_ctrl;

   localparam int MDC = 32;

   // Packed control view: {pc_en, fd_en, fd_flush, dx_en, dx_bubble, md_start, md_busy}
   localparam logic [6:0] C_RUN     = 7'b1101000;
   localparam logic [6:0] C_LU      = 7'b0001100;
   localparam logic [6:0] C_BRANCH  = 7'b1111100;
   localparam logic [6:0] C_ISSUE   = 7'b0000010;
   localparam logic [6:0] C_MD_BUSY = 7'b0000001;
   localparam logic [6:0] C_MD_LAST = 7'b0001101;

   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] fd_opcode, fd_rs, fd_rt, dx_opcode, dx_rd, dx_aluOp;
   logic       branch_taken;

   logic        pc_enable, fd_enable, fd_flush, dx_enable, dx_bubble, md_start, md_busy;
   logic [15:0] stall_cycles;
   logic        s_pc_enable, s_fd_enable, s_fd_flush, s_dx_enable, s_dx_bubble, s_md_start, s_md_busy;
   logic [3:0]  s_stall_cycles;
   logic [6:0]  ctrl;

   int n_total = 0;
   int n_bad   = 0;

   assign ctrl = {pc_enable, fd_enable, fd_flush, dx_enable, dx_bubble, md_start, md_busy};

   always #5 clock = ~clock;

   pipeline_hazard_ctrl #(.MD_CYCLES(MDC), .STALL_CNT_W(16)) dut (
      .clock(clock), .reset(reset),
      .fd_opcode(fd_opcode), .fd_rs(fd_rs), .fd_rt(fd_rt),
      .dx_opcode(dx_opcode), .dx_rd(dx_rd), .dx_aluOp(dx_aluOp),
      .branch_taken(branch_taken),
      .pc_enable(pc_enable), .fd_enable(fd_enable), .fd_flush(fd_flush),
      .dx_enable(dx_enable), .dx_bubble(dx_bubble),
      .md_start(md_start), .md_busy(md_busy), .stall_cycles(stall_cycles)
   );

   pipeline_hazard_ctrl #(.MD_CYCLES(MDC), .STALL_CNT_W(4)) dut_sat (
      .clock(clock), .reset(reset),
      .fd_opcode(fd_opcode), .fd_rs(fd_rs), .fd_rt(fd_rt),
      .dx_opcode(dx_opcode), .dx_rd(dx_rd), .dx_aluOp(dx_aluOp),
      .branch_taken(branch_taken),
      .pc_enable(s_pc_enable), .fd_enable(s_fd_enable), .fd_flush(s_fd_flush),
      .dx_enable(s_dx_enable), .dx_bubble(s_dx_bubble),
      .md_start(s_md_start), .md_busy(s_md_busy), .stall_cycles(s_stall_cycles)
   );

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic dx_nop();
      dx_opcode = 5'd0; dx_rd = 5'd0; dx_aluOp = 5'd0;
   endtask

   // Issue a mul/div and step through the whole hold; br_at pulses
   // branch_taken on that MD_BUSY cycle to show it is ignored.
   task automatic run_md(input logic [4:0] aluop, input int br_at);
      dx_opcode = 5'b00000; dx_aluOp = aluop; dx_rd = 5'd7;
      #2 check_val("md_issue", {25'd0, ctrl}, {25'd0, C_ISSUE});
      for (int i = 0; i < MDC; i++) begin
         tick();
         branch_taken = (i == br_at);
         #2;
         if (i == MDC - 1) check_val("md_last", {25'd0, ctrl}, {25'd0, C_MD_LAST});
         else              check_val("md_busy", {25'd0, ctrl}, {25'd0, C_MD_BUSY});
      end
      tick();
      branch_taken = 1'b0;
      dx_nop();
      #2 check_val("md_after", {25'd0, ctrl}, {25'd0, C_RUN});
   endtask

   initial begin
      reset = 1'b1; branch_taken = 1'b0;
      fd_opcode = 5'd0; fd_rs = 5'd0; fd_rt = 5'd0;
      dx_nop();
      #3 check_val("rst_ctrl", {25'd0, ctrl}, {25'd0, C_RUN});
      check_val("rst_stall", {16'd0, stall_cycles}, 32'd0);
      tick(); tick();
      reset = 1'b0;
      #2 check_val("idle_ctrl", {25'd0, ctrl}, {25'd0, C_RUN});

      // Load-use stall, one cycle, then the bubble clears the hazard
      tick();
      dx_opcode = 5'b01000; dx_rd = 5'd5; fd_rs = 5'd5;
      #2 check_val("lu_ctrl", {25'd0, ctrl}, {25'd0, C_LU});
      tick();
      dx_nop();
      #2 check_val("lu_after", {25'd0, ctrl}, {25'd0, C_RUN});
      check_val("lu_stall", {16'd0, stall_cycles}, 32'd1);

      // Load to $0 never stalls
      dx_opcode = 5'b01000; dx_rd = 5'd0; fd_rs = 5'd0;
      #2 check_val("lu_r0", {25'd0, ctrl}, {25'd0, C_RUN});
      tick();
      check_val("lu_r0_stall", {16'd0, stall_cycles}, 32'd1);

      // Taken branch beats a simultaneous load-use match on rt
      dx_opcode = 5'b01000; dx_rd = 5'd3; fd_rs = 5'd1; fd_rt = 5'd3;
      branch_taken = 1'b1;
      #2 check_val("br_lu_ctrl", {25'd0, ctrl}, {25'd0, C_BRANCH});
      tick();
      branch_taken = 1'b0; dx_nop(); fd_rs = 5'd0; fd_rt = 5'd0;
      #2 check_val("br_lu_stall", {16'd0, stall_cycles}, 32'd1);

      // mul: 33 stalled cycles, branch ignored mid-sequence
      run_md(5'b00110, 5);
      check_val("mul_stall", {16'd0, stall_cycles}, 32'd34);

      // div takes the same path
      tick();
      run_md(5'b00111, -1);
      check_val("div_stall", {16'd0, stall_cycles}, 32'd67);

      // Reset while MD_BUSY with counter at 10 aborts immediately
      tick();
      dx_opcode = 5'b00000; dx_aluOp = 5'b00110; dx_rd = 5'd4;
      #2 check_val("rst_md_issue", {25'd0, ctrl}, {25'd0, C_ISSUE});
      for (int k = 0; k < MDC - 10; k++) tick();
      #1 check_val("rst_md_busy", {25'd0, ctrl}, {25'd0, C_MD_BUSY});
      #1 reset = 1'b1;
      #1 check_val("rst_md_ctrl", {25'd0, ctrl}, {25'd0, C_RUN});
      check_val("rst_md_stall", {16'd0, stall_cycles}, 32'd0);
      check_val("rst_md_sstall", {28'd0, s_stall_cycles}, 32'd0);
      tick();
      dx_nop();
      reset = 1'b0;
      #2 check_val("rst_rel_ctrl", {25'd0, ctrl}, {25'd0, C_RUN});
      tick();
      check_val("rst_rel_run", {25'd0, ctrl}, {25'd0, C_RUN});

      // 20 consecutive load-use stalls (hazard held): 4-bit counter pins at 15
      dx_opcode = 5'b01000; dx_rd = 5'd9; fd_rs = 5'd9;
      #2 check_val("sat_ctrl", {25'd0, ctrl}, {25'd0, C_LU});
      for (int k = 0; k < 15; k++) tick();
      check_val("sat_15", {28'd0, s_stall_cycles}, 32'd15);
      for (int k = 0; k < 5; k++) tick();
      check_val("sat_hold", {28'd0, s_stall_cycles}, 32'd15);
      check_val("sat_wide", {16'd0, stall_cycles}, 32'd20);
      dx_nop(); fd_rs = 5'd0;
      tick();
      check_val("end_ctrl", {25'd0, ctrl}, {25'd0, C_RUN});

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
